// File: rtl/axis_pkg.sv
// Shared types and helpers for the FIFO-to-AXI-Stream packer.
package axis_pkg;

    // FILL: output register free; HOLD: output beat valid
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned MAX_RATIO = 32;

    // Lane mask with the lowest 'count' bits set, limited to 'ratio' lanes.
    function automatic logic [MAX_RATIO-1:0] keep_from_count(input int unsigned count,
                                                             input int unsigned ratio);
        logic [MAX_RATIO-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_RATIO; i++) begin
            if ((i < count) && (i < ratio)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_fifo_packer_if.sv
// Wide AXI-Stream output bundle of the packer.
interface axis_fifo_packer_if #(
    parameter int width = 8,
    parameter int ratio = 4
);
    logic                     m_valid;
    logic                     m_ready;
    logic [width*ratio-1:0]   m_data;
    logic [ratio-1:0]         m_keep;
    logic                     m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_keep,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_keep,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/axis_pkt_counter.sv
// Counts accepted beats within a packet and decides m_last for the beat being loaded.
module axis_pkt_counter #(
    parameter int len_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [len_width-1:0] pkt_words,
    input  logic                 handshake,
    input  logic                 last_out,
    output logic                 pkt_last
);

    logic [len_width-1:0] wcnt;
    logic [len_width-1:0] wcnt_eff;

    // Count as it will stand after this cycle's handshake, so a beat loaded
    // back-to-back with a handshake sees the updated position.
    always_comb begin
        wcnt_eff = wcnt;
        if (handshake) begin
            wcnt_eff = last_out ? '0 : wcnt + 1'b1;
        end
        pkt_last = (pkt_words != '0) && (wcnt_eff == (pkt_words - 1'b1));
    end

    // Word counter: clear on the last beat's handshake, otherwise advance per handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt_eff;
        end
    end

endmodule

// File: rtl/axis_fifo_packer.sv
// Packs 'ratio' narrow FIFO entries into one wide AXI-Stream beat.
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | output register free; entries accumulate, a close loads it
// HOLD  | beat presented (m_valid=1); accumulation continues up to
//       | ratio-1 lanes, the completing pop waits for a handshake
module axis_fifo_packer
    import axis_pkg::*;
#(
    parameter int width     = 8,
    parameter int ratio     = 4,
    parameter int len_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic [width-1:0]      read_data,
    output logic                  pop,
    input  logic                  flush,
    input  logic [len_width-1:0]  pkt_words,
    axis_fifo_packer_if.master    m_axis
);

    localparam int LANE_W = $clog2(ratio);
    localparam int WORD_W = width * ratio;

    state_t              state;
    state_t              state_nxt;
    logic [LANE_W-1:0]   lane_cnt;
    logic [WORD_W-1:0]   acc;
    logic [WORD_W-1:0]   acc_nxt;
    logic                flush_pend;

    logic [WORD_W-1:0]   out_data;
    logic [ratio-1:0]    out_keep;
    logic                out_last;

    logic                free;
    logic                handshake;
    logic                last_lane;
    logic                full_close;
    logic                flush_req;
    logic                flush_close;
    logic                word_close;
    logic [LANE_W:0]     filled;
    logic [ratio-1:0]    keep_nxt;
    logic                pkt_last;
    logic                load_last;

    assign m_axis.m_valid = (state == HOLD);
    assign m_axis.m_data  = out_data;
    assign m_axis.m_keep  = out_keep;
    assign m_axis.m_last  = out_last;

    // Pop/close decisions; a flush counts a pop happening in the same cycle.
    always_comb begin
        free        = (state == FILL) || m_axis.m_ready;
        handshake   = (state == HOLD) && m_axis.m_ready;
        last_lane   = (lane_cnt == LANE_W'(ratio - 1));
        pop         = ~rst & ~empty & ((state == FILL) | ~last_lane | m_axis.m_ready);
        full_close  = pop & last_lane;
        flush_req   = flush | flush_pend;
        filled      = {1'b0, lane_cnt} + {{LANE_W{1'b0}}, pop};
        flush_close = flush_req & free & (filled != '0);
        word_close  = full_close | flush_close;
        keep_nxt    = ratio'(keep_from_count(32'(filled), ratio));
        load_last   = flush_close | pkt_last;
    end

    // Partial word including this cycle's entry; unfilled lanes stay zero.
    always_comb begin
        acc_nxt = acc;
        if (pop) begin
            acc_nxt[int'(lane_cnt) * width +: width] = read_data;
        end
    end

    axis_pkt_counter #(
        .len_width (len_width)
    ) u_pkt_counter (
        .clk       (clk),
        .rst       (rst),
        .pkt_words (pkt_words),
        .handshake (handshake),
        .last_out  (out_last),
        .pkt_last  (pkt_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a close always lands in HOLD; a handshake without a close frees the register.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (word_close) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_nxt = word_close ? HOLD : FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Accumulator, output register and pending flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt   <= '0;
            acc        <= '0;
            flush_pend <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
        end else begin
            if (word_close) begin
                out_data <= acc_nxt;
                out_keep <= keep_nxt;
                out_last <= load_last;
                lane_cnt <= '0;
                acc      <= '0;
            end else begin
                acc <= acc_nxt;
                if (pop) begin
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end

            // Resolved once the output can take a word: closes it, or drops if nothing is filled.
            if (flush_req && free) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo_packer.sv
// Directed bench for axis_fifo_packer with a queue-based scoreboard of expected beats.
module tb_axis_fifo_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        empty;
    logic [7:0]  read_data;
    logic        pop;
    logic        flush;
    logic [7:0]  pkt_words;

    axis_fifo_packer_if #(.width(8), .ratio(4)) m_if ();

    axis_fifo_packer #(
        .width     (8),
        .ratio     (4),
        .len_width (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .read_data (read_data),
        .pop       (pop),
        .flush     (flush),
        .pkt_words (pkt_words),
        .m_axis    (m_if)
    );

    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];
    beat_t mon_exp;

    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign empty     = (rd_ptr == wr_ptr);
    assign read_data = mem[rd_ptr[7:0]];

    // FIFO model: head advances on every pop seen at the clock edge.
    always @(posedge clk) begin
        if (pop) rd_ptr <= rd_ptr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr++;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        sb.push_back(b);
    endtask

    task automatic wait_sb_empty(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL %s: observed pending=%0d expected pending=0", tag, sb.size());
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (m_if.m_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(m_if.m_valid), 32'd1);
    endtask

    // Output monitor: every accepted beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && m_if.m_valid && m_if.m_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_beat: observed data=%0h expected no beat", m_if.m_data);
            end
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                chk("beat_data", m_if.m_data, mon_exp.data);
                chk("beat_keep", 32'(m_if.m_keep), 32'(mon_exp.keep));
                chk("beat_last", 32'(m_if.m_last), 32'(mon_exp.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npop;

        rst         = 1'b1;
        flush       = 1'b0;
        pkt_words   = 8'd2;
        m_if.m_ready = 1'b1;
        step(2);

        // Basic pack: entries queued during reset must not pop until release.
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
        expect_beat(32'h44332211, 4'hF, 1'b0);
        expect_beat(32'h88776655, 4'hF, 1'b1);
        @(negedge clk);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_valid", 32'(m_if.m_valid), 32'd0);
        chk("rst_data", m_if.m_data, 32'd0);
        chk("rst_keep", 32'(m_if.m_keep), 32'd0);
        chk("rst_last", 32'(m_if.m_last), 32'd0);
        chk("rst_wcnt", 32'(dut.u_pkt_counter.wcnt), 32'd0);
        chk("rst_flush_pend", 32'(dut.flush_pend), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("basic_pop_run", 32'(pop), 32'd1);
        end
        @(negedge clk);
        chk("basic_pop_drained", 32'(pop), 32'd0);
        wait_sb_empty("basic_beats", 30);
        step();
        chk("basic_wcnt", 32'(dut.u_pkt_counter.wcnt), 32'd0);

        // Back-pressure: beat held, three lanes accumulate, completing pop waits for ready.
        m_if.m_ready = 1'b0;
        pkt_words    = 8'd0;
        for (int i = 1; i <= 9; i++) push(8'(i * 8'h11));
        expect_beat(32'h44332211, 4'hF, 1'b0);
        expect_beat(32'h88776655, 4'hF, 1'b0);
        expect_beat(32'h00000099, 4'h1, 1'b1);
        wait_valid("bp_valid", 20);
        npop = 0;
        for (int i = 0; i < 6; i++) begin
            if (pop) npop++;
            chk("bp_pop_pattern", 32'(pop), (i < 3) ? 32'd1 : 32'd0);
            chk("bp_data_stable", m_if.m_data, 32'h44332211);
            chk("bp_valid_held", 32'(m_if.m_valid), 32'd1);
            if (i < 5) @(negedge clk);
        end
        chk("bp_pop_count", 32'(npop), 32'd3);
        @(posedge clk);
        #1;
        m_if.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_in_handshake", 32'(pop), 32'd1);
        @(negedge clk);
        chk("bp_next_valid", 32'(m_if.m_valid), 32'd1);
        chk("bp_next_data", m_if.m_data, 32'h88776655);
        step(2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_sb_empty("bp_beats", 30);
        step();
        chk("bp_wcnt", 32'(dut.u_pkt_counter.wcnt), 32'd0);

        // Partial flush of two lanes.
        push(8'hAA);
        push(8'hBB);
        expect_beat(32'h0000BBAA, 4'h3, 1'b1);
        step(3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("pflush_valid", 32'(m_if.m_valid), 32'd1);
        chk("pflush_data", m_if.m_data, 32'h0000BBAA);
        chk("pflush_keep", 32'(m_if.m_keep), 32'h3);
        chk("pflush_last", 32'(m_if.m_last), 32'd1);
        wait_sb_empty("pflush_beats", 20);
        step();
        chk("pflush_pend_clear", 32'(dut.flush_pend), 32'd0);

        // Empty flush: no beat, pending flag dropped, next four entries form a normal beat.
        step(2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("eflush_no_valid", 32'(m_if.m_valid), 32'd0);
        chk("eflush_pend_clear", 32'(dut.flush_pend), 32'd0);
        step();
        chk("eflush_still_idle", 32'(m_if.m_valid), 32'd0);
        for (int i = 1; i <= 4; i++) push(8'(i));
        expect_beat(32'h04030201, 4'hF, 1'b0);
        wait_sb_empty("eflush_beat", 20);
        step();
        chk("eflush_wcnt", 32'(dut.u_pkt_counter.wcnt), 32'd1);

        // Flush together with the completing pop.
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        step(5);
        push(8'hC4);
        flush = 1'b1;
        expect_beat(32'hC4C3C2C1, 4'hF, 1'b1);
        step();
        flush = 1'b0;
        chk("cflush_valid", 32'(m_if.m_valid), 32'd1);
        chk("cflush_keep", 32'(m_if.m_keep), 32'hF);
        chk("cflush_last", 32'(m_if.m_last), 32'd1);
        wait_sb_empty("cflush_beat", 20);
        step();
        chk("cflush_wcnt", 32'(dut.u_pkt_counter.wcnt), 32'd0);
        chk("cflush_pend_clear", 32'(dut.flush_pend), 32'd0);

        // Reset while holding a beat with two lanes filled; single-word packets afterwards.
        m_if.m_ready = 1'b0;
        pkt_words    = 8'd1;
        for (int i = 1; i <= 6; i++) push(8'(8'hD0 + i));
        step(10);
        chk("rhold_valid", 32'(m_if.m_valid), 32'd1);
        chk("rhold_data", m_if.m_data, 32'hD4D3D2D1);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(8'hE0 + i));
        @(negedge clk);
        chk("rhold_pop_in_reset", 32'(pop), 32'd0);
        @(posedge clk);
        #1;
        chk("rhold_valid_dropped", 32'(m_if.m_valid), 32'd0);
        chk("rhold_pop_still_low", 32'(pop), 32'd0);
        step();
        rst = 1'b0;
        m_if.m_ready = 1'b1;
        expect_beat(32'hE4E3E2E1, 4'hF, 1'b1);
        wait_sb_empty("rhold_new_beat", 20);
        step(2);
        chk("final_idle", 32'(m_if.m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
